// File: rtl/fm_demod_div_feeder_if.sv
// Stream bundle between the I/Q source, the discriminator feeder and the signed divider.
// The slave view is the feeder itself; the master view is whoever drives samples and takes operands.
interface fm_demod_div_feeder_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_i;
  logic signed [IN_W-1:0]  in_q;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_dividend;
  logic signed [OUT_W-1:0] out_divisor;
  logic                    out_quad;
  logic                    out_neg;

  modport slave (
    input  in_valid, in_i, in_q, out_ready,
    output in_ready, out_valid, out_dividend, out_divisor, out_quad, out_neg
  );

  modport master (
    output in_valid, in_i, in_q, out_ready,
    input  in_ready, out_valid, out_dividend, out_divisor, out_quad, out_neg
  );
endinterface

// File: rtl/fm_demod_div_feeder.sv
// FM discriminator front end: forms x[n]*conj(x[n-1]) and emits qarctan dividend/divisor operands
// through a 3-stage lockstep pipeline that stalls as a whole under divider backpressure.
module fm_demod_div_feeder #(
  parameter int IN_W       = 16,
  parameter int PROD_SHIFT = 10,
  parameter int FRAC_BITS  = 6,
  parameter int OUT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fm_demod_div_feeder_if.slave bus
);

  localparam int PW = 2 * IN_W;        // product width
  localparam int SW = PW + 1;          // sum width before the shift
  localparam int XW = SW - PROD_SHIFT; // x / y width after the shift
  localparam int AW = XW + 1;          // |y|+1 needs one more bit than y

  logic                    adv;
  logic                    accept;
  logic                    primed;
  logic signed [IN_W-1:0]  prev_i;
  logic signed [IN_W-1:0]  prev_q;
  logic                    s1_valid;
  logic                    s2_valid;
  logic                    out_valid_q;

  logic signed [PW-1:0]    p_ii;
  logic signed [PW-1:0]    p_qq;
  logic signed [PW-1:0]    p_qi;
  logic signed [PW-1:0]    p_iq;
  logic signed [XW-1:0]    x_q;
  logic signed [AW-1:0]    ay_q;
  logic                    neg_q;

  logic signed [OUT_W-1:0] dividend_q;
  logic signed [OUT_W-1:0] divisor_q;
  logic                    quad_q;
  logic                    out_neg_q;

  logic signed [SW-1:0]    sum_x;
  logic signed [SW-1:0]    sum_y;
  logic signed [XW-1:0]    x_d;
  logic signed [XW-1:0]    y_d;
  logic signed [AW-1:0]    y_ext;
  logic signed [AW-1:0]    ay_d;
  logic signed [OUT_W-1:0] x_w;
  logic signed [OUT_W-1:0] ay_w;
  logic signed [OUT_W-1:0] diff_d;
  logic signed [OUT_W-1:0] dividend_d;
  logic signed [OUT_W-1:0] divisor_d;

  function automatic logic signed [PW-1:0] smul(input logic signed [IN_W-1:0] a,
                                                input logic signed [IN_W-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // One enable for every stage: the pipe only moves when the output slot is free or being taken.
  assign adv          = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && adv;
  assign bus.in_ready = adv;

  assign bus.out_valid    = out_valid_q;
  assign bus.out_dividend = dividend_q;
  assign bus.out_divisor  = divisor_q;
  assign bus.out_quad     = quad_q;
  assign bus.out_neg      = out_neg_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    diff_d    = '0;
    divisor_d = '0;

    sum_x = {p_ii[PW-1], p_ii} + {p_qq[PW-1], p_qq};
    sum_y = {p_qi[PW-1], p_qi} - {p_iq[PW-1], p_iq};
    // Dropping the low bits of a two's-complement value is a floor shift.
    x_d   = sum_x[SW-1:PROD_SHIFT];
    y_d   = sum_y[SW-1:PROD_SHIFT];
    y_ext = {y_d[XW-1], y_d};
    ay_d  = (y_d[XW-1] ? -y_ext : y_ext) + AW'(1);

    x_w  = {{(OUT_W-XW){x_q[XW-1]}}, x_q};
    ay_w = {{(OUT_W-AW){1'b0}}, ay_q};
    if (x_q[XW-1]) begin
      diff_d    = x_w + ay_w;
      divisor_d = ay_w - x_w;
    end else begin
      diff_d    = x_w - ay_w;
      divisor_d = x_w + ay_w;
    end
    dividend_d = diff_d <<< FRAC_BITS;
  end

  // NOTE: datapath registers carry no reset; the stage valids decide whether their contents matter.
  always_ff @(posedge clk) begin
    if (accept && primed) begin
      p_ii <= smul(bus.in_i, prev_i);
      p_qq <= smul(bus.in_q, prev_q);
      p_qi <= smul(bus.in_q, prev_i);
      p_iq <= smul(bus.in_i, prev_q);
    end
    if (adv) begin
      x_q   <= x_d;
      ay_q  <= ay_d;
      neg_q <= y_d[XW-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      primed      <= 1'b0;
      prev_i      <= '0;
      prev_q      <= '0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quad_q      <= 1'b0;
      out_neg_q   <= 1'b0;
    end else if (adv) begin
      // The first sample after reset only seeds prev; it has no predecessor to multiply with.
      s1_valid <= accept && primed;
      if (accept) begin
        prev_i <= bus.in_i;
        prev_q <= bus.in_q;
        primed <= 1'b1;
      end
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        dividend_q <= dividend_d;
        divisor_q  <= divisor_d;
        quad_q     <= x_q[XW-1];
        out_neg_q  <= neg_q;
      end
    end
  end

endmodule

// File: tb/tb_fm_demod_div_feeder.sv
// Randomized and directed bench for fm_demod_div_feeder; a longint arithmetic model
// predicts every operand set, and a queue scoreboard checks order, count and stall behaviour.
module tb_fm_demod_div_feeder;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  typedef struct {
    longint dividend;
    longint divisor;
    bit     quad;
    bit     neg;
  } ops_t;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fm_demod_div_feeder_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fm_demod_div_feeder #(
    .IN_W(IN_W), .PROD_SHIFT(10), .FRAC_BITS(6), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  ops_t   sb[$];
  bit     m_primed;
  longint m_pi, m_pq;
  int     n_vec, n_err;
  int     cyc, acc_cyc, out_cyc, out_cnt;
  bit     last_acc;
  bit     hold;
  ops_t   held, last_out;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: discriminator product and qarctan operands in plain 64-bit arithmetic.
  function automatic ops_t model(input longint pi, input longint pq,
                                 input longint i, input longint q);
    ops_t   r;
    longint x, y, ay;
    x  = (i * pi + q * pq) >>> 10;
    y  = (q * pi - i * pq) >>> 10;
    ay = ((y < 0) ? -y : y) + 1;
    r.quad     = (x < 0);
    r.neg      = (y < 0);
    r.dividend = ((x < 0) ? (x + ay) : (x - ay)) * 64;
    r.divisor  = (x < 0) ? (ay - x) : (x + ay);
    return r;
  endfunction

  function automatic logic signed [IN_W-1:0] rnd_s();
    case ($urandom_range(0, 7))
      0:       return 16'sh8000;
      1:       return 16'sh7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock of stimulus plus monitoring; handshakes are resolved just after the falling edge.
  task automatic cycle(input bit rst, input bit iv, input logic signed [IN_W-1:0] ii,
                       input logic signed [IN_W-1:0] iq, input bit ordy);
    ops_t e, o;
    @(negedge clk);
    reset_n       = !rst;
    bus.in_valid  = iv;
    bus.in_i      = ii;
    bus.in_q      = iq;
    bus.out_ready = ordy;
    #1;
    cyc++;
    last_acc = 1'b0;
    if (hold) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_dividend", bus.out_dividend, held.dividend);
      check("hold_divisor", bus.out_divisor, held.divisor);
      check("hold_quad", bus.out_quad, held.quad);
      check("hold_neg", bus.out_neg, held.neg);
    end
    if (rst) begin
      sb.delete();
      m_primed = 1'b0;
      hold     = 1'b0;
      return;
    end
    o.dividend = longint'(bus.out_dividend);
    o.divisor  = longint'(bus.out_divisor);
    o.quad     = bus.out_quad;
    o.neg      = bus.out_neg;
    if (bus.out_valid === 1'b1) begin
      if (!ordy) begin
        check("stall_in_ready", bus.in_ready, 0);
      end else if (sb.size() == 0) begin
        check("spurious_out", bus.out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("dividend", bus.out_dividend, e.dividend);
        check("divisor", bus.out_divisor, e.divisor);
        check("quad", bus.out_quad, e.quad);
        check("neg", bus.out_neg, e.neg);
        check("divisor_pos", bus.out_divisor >= 1, 1);
        out_cyc  = cyc;
        out_cnt++;
        last_out = o;
      end
    end
    hold = (bus.out_valid === 1'b1) && !ordy;
    held = o;
    if (iv && bus.in_ready === 1'b1) begin
      if (m_primed) sb.push_back(model(m_pi, m_pq, longint'(ii), longint'(iq)));
      m_primed = 1'b1;
      m_pi     = longint'(ii);
      m_pq     = longint'(iq);
      acc_cyc  = cyc;
      last_acc = 1'b1;
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, '0, 1'b1);
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_dividend", bus.out_dividend, 0);
    check("rst_divisor", bus.out_divisor, 0);
    check("rst_quad", bus.out_quad, 0);
    check("rst_neg", bus.out_neg, 0);
  endtask

  task automatic send(input logic signed [IN_W-1:0] ii, input logic signed [IN_W-1:0] iq);
    for (int k = 0; k < 50; k++) begin
      cycle(1'b0, 1'b1, ii, iq, 1'b1);
      if (last_acc) return;
    end
    check("send_timeout", last_acc, 1);
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, 1'b0, '0, '0, 1'b1);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic run_pair(input string tag,
                          input logic signed [IN_W-1:0] ai, input logic signed [IN_W-1:0] aq,
                          input logic signed [IN_W-1:0] bi, input logic signed [IN_W-1:0] bq,
                          input longint e_div, input longint e_dvs, input bit e_quad, input bit e_neg);
    do_reset();
    out_cnt = 0;
    send(ai, aq);
    send(bi, bq);
    drain(8);
    check({tag, "_count"}, out_cnt, 1);
    check({tag, "_latency"}, out_cyc - acc_cyc, 3);
    check({tag, "_dividend"}, last_out.dividend, e_div);
    check({tag, "_divisor"}, last_out.divisor, e_dvs);
    check({tag, "_quad"}, last_out.quad, e_quad);
    check({tag, "_neg"}, last_out.neg, e_neg);
  endtask

  logic signed [IN_W-1:0] s_i[20];
  logic signed [IN_W-1:0] s_q[20];
  logic signed [IN_W-1:0] r_i, r_q;
  bit                     r_v, r_rdy;
  int                     idx;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; out_cnt = 0; hold = 1'b0; m_primed = 1'b0;
    acc_cyc = 0; out_cyc = 0; last_acc = 1'b0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_i = '0; bus.in_q = '0; bus.out_ready = 1'b1;

    run_pair("t1", 16'sd1000, 16'sd0, 16'sd1000, 16'sd0, 62400, 977, 1'b0, 1'b0);
    run_pair("t2a", 16'sd1000, 16'sd0, 16'sd0, 16'sd1000, -62528, 977, 1'b0, 1'b0);
    // Floor shift of -976.56 gives y=-977, so |y|+1 is one larger than in the positive case.
    run_pair("t2b", 16'sd1000, 16'sd0, 16'sd0, -16'sd1000, -62592, 978, 1'b0, 1'b1);
    run_pair("t3", 16'sd1000, 16'sd0, -16'sd1000, 16'sd0, -62464, 978, 1'b1, 1'b0);

    // Continuous stream with a five-cycle divider stall in the middle.
    do_reset();
    out_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      s_i[k] = rnd_s();
      s_q[k] = rnd_s();
    end
    idx = 0;
    for (int t = 0; t < 200 && idx < 20; t++) begin
      cycle(1'b0, 1'b1, s_i[idx], s_q[idx], !(t >= 8 && t < 13));
      if (last_acc) idx++;
    end
    check("t4_accepted", idx, 20);
    drain(8);
    check("t4_count", out_cnt, 19);

    // Reset with samples in flight, then a fresh pair.
    do_reset();
    for (int k = 0; k < 4; k++) send(rnd_s(), rnd_s());
    do_reset();
    out_cnt = 0;
    send(16'sd3000, -16'sd1200);
    send(-16'sd2500, 16'sd4100);
    drain(8);
    check("t5_count", out_cnt, 1);

    // Random traffic with random bubbles and backpressure, holding a sample until taken.
    do_reset();
    r_v = 1'b0; r_i = '0; r_q = '0;
    for (int t = 0; t < 3000; t++) begin
      if (!r_v || last_acc) begin
        r_v = ($urandom_range(0, 3) != 0);
        r_i = rnd_s();
        r_q = rnd_s();
      end
      r_rdy = ($urandom_range(0, 9) < 7);
      cycle(1'b0, r_v, r_i, r_q, r_rdy);
    end
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
